pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch sequencer for the Beta-style RISC core. It consumes the `PCSEL` selection produced by the control logic and computes the next PC, with supervisor-bit protection. It fetches instructions over a request/acknowledge instruction-memory port and presents `OPCODE`, `IRQ` and `pc_31` back to the control logic, one instruction at a time.

## Interface
- `RESET_VECTOR`, 32'h8000_0000: PC loaded on reset.
- `ILLOP_VECTOR`, 32'h8000_0004: target when `PCSEL`=3 or 5..7.
- `XADR_VECTOR`, 32'h8000_0008: interrupt target, `PCSEL`=4.
- `CLK` in 1: single clock; all state on rising edge.
- `RESET_N` in 1: synchronous, active-low reset.
- `PCSEL` in 3: next-PC select from control logic, 0=PC+4, 1=branch, 2=JMP, 3=ILLOP, 4=XADR.
- `JT` in 32: jump target (Ra value) for `PCSEL`=2.
- `EXEC_DONE` in 1: datapath finished the current instruction; commit next PC.
- `IMEM_ACK` in 1: instruction memory data valid.
- `IMEM_RDATA` in 32: fetched instruction word.
- `IRQ_IN` in 1: external interrupt request, level, asynchronous to `CLK`.
- `IMEM_REQ` out 1: fetch request.
- `IMEM_ADDR` out 32: fetch address; equals `PC` while `IMEM_REQ`=1.
- `INSTR` out 32: current instruction register.
- `OPCODE` out 6: `INSTR[31:26]`.
- `INSTR_VALID` out 1: high throughout EXEC.
- `PC` out 32: address of the current instruction.
- `PC_PLUS4` out 32: `PC`+4, used as link/return value.
- `pc_31` out 1: `PC[31]`, supervisor bit.
- `IRQ` out 1: interrupt request to control logic, held stable for a whole EXEC.

## Operation
- States: RST, FETCH, EXEC.
- RST → FETCH on the first edge with `RESET_N`=1.
- FETCH: `IMEM_REQ`=1, `IMEM_ADDR`=`PC`. On `IMEM_ACK`=1, capture `IMEM_RDATA` into `INSTR`, drop `IMEM_REQ`, go to EXEC.
- EXEC: `INSTR_VALID`=1. `PCSEL` and `JT` are sampled only on the edge where `EXEC_DONE`=1. That edge loads the next PC, returns to FETCH and raises `IMEM_REQ`.
- Next PC, all arithmetic mod 2^32:
  - 0: `PC`+4.
  - 1: `PC`+4+{SXT(`INSTR[15:0]`),2'b00}; bit 31 is forced to the old `PC[31]`.
  - 2: {`PC[31]` & `JT[31]`, `JT[30:2]`, 2'b00}. User mode can never enter supervisor mode via JMP.
  - 3, 5, 6, 7: `ILLOP_VECTOR`.
  - 4: `XADR_VECTOR`.
- Bits [1:0] of the PC are always 0.
- Interrupts:
  - Synchronized `IRQ_IN` sets `irq_pending`.
  - `IRQ` = `irq_pending` & ~`PC[31]`, registered on the FETCH→EXEC edge and held constant during EXEC.
  - `irq_pending` clears on the commit edge with `PCSEL`=4.
  - `IRQ_IN` rising during EXEC is deferred to the next instruction.
- Reset values: `PC`=`RESET_VECTOR`, `INSTR`=0, `IMEM_REQ`=0, `INSTR_VALID`=0, `IRQ`=0, `irq_pending`=0, state RST.
- Reset mid-fetch or mid-exec:
  - Outputs take reset values on that edge.
  - The outstanding request is abandoned.
  - An `IMEM_ACK` arriving in RST, or in the first FETCH cycle after RST, for the old address is indistinguishable, so memory must drop `ACK` when `REQ` falls.
- `IMEM_ACK` outside FETCH is ignored.
- `EXEC_DONE` outside EXEC is ignored.

## Timing
- Best case is 2 cycles per instruction: FETCH with `ACK` in the same cycle as `REQ`, then EXEC with `EXEC_DONE` in its first cycle.
- Each cycle without `IMEM_ACK` adds one FETCH cycle.
- Each cycle without `EXEC_DONE` adds one EXEC cycle.
- `OPCODE`, `PC` and `IRQ` are stable from the first EXEC cycle until the commit edge. The control logic may decode combinationally from them.
- `PC` updates exactly on the commit edge. `IMEM_REQ`/`IMEM_ADDR` reflect the new PC in the following cycle.
- Interrupt latency from `IRQ_IN` to `irq_pending`: 1 cycle, or 2 cycles with sync (see Configuration).

## Configuration
- `PC_FETCH_IRQ_SYNC_EN` defined: `IRQ_IN` passes through a two-flop synchronizer before setting `irq_pending`. `IRQ_IN` may be fully asynchronous.
- Not defined: `IRQ_IN` is sampled by a single flop. `IRQ_IN` must be synchronous to `CLK`.

## Structure
- Shared package `beta_pkg` holds:
  - `PCSEL` encodings `PCSEL_PC4`, `PCSEL_BR`, `PCSEL_JMP`, `PCSEL_ILLOP`, `PCSEL_XADR`.
  - Default vector constants.
  - The fetch state encoding `FS_RST`, `FS_FETCH`, `FS_EXEC`.
- One sub-module, `irq_sync`: synchronizer plus pending latch with clear input. Its depth is set by the macro.

## Test plan
- Reset, then `ACK`=1 immediately and `EXEC_DONE`=1 with `PCSEL`=0 → `IMEM_ADDR` sequence 8000_0000, 8000_0004, 8000_0008, one instruction per 2 cycles.
- Branch: `PC`=0000_0100, `INSTR[15:0]`=16'hFFFE, `PCSEL`=1 → next `PC`=0000_00FC. Same with `PC`=8000_0100 → 8000_00FC.
- JMP from user mode: `PC`=0000_0040, `JT`=8000_1234, `PCSEL`=2 → `PC`=0000_1234. From `PC`=8000_0040 → 8000_1234.
- `PCSEL`=6 → `PC`=8000_0004. `IMEM_ACK` held low 3 cycles → FETCH lasts 4 cycles with `IMEM_ADDR` constant.
- `IRQ_IN` pulsed mid-EXEC with `PC[31]`=0 → `IRQ` stays 0 until the next EXEC, then 1. `PCSEL`=4 commit → `PC`=8000_0008, `IRQ`=0 after. `IRQ_IN` with `PC[31]`=1 → `IRQ` stays 0.
- `RESET_N`=0 asserted while `IMEM_REQ`=1 → next edge `IMEM_REQ`=0, `PC`=8000_0000, `INSTR_VALID`=0. A stray `IMEM_ACK` during reset is ignored.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared definitions for the Beta-style core front end: PCSEL encodings,
// default exception/reset vectors and the fetch sequencer state encoding.
package beta_pkg;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h8000_0000;
    localparam logic [31:0] DEF_ILLOP_VECTOR = 32'h8000_0004;
    localparam logic [31:0] DEF_XADR_VECTOR  = 32'h8000_0008;

    typedef enum logic [2:0] {
        PCSEL_PC4   = 3'd0,
        PCSEL_BR    = 3'd1,
        PCSEL_JMP   = 3'd2,
        PCSEL_ILLOP = 3'd3,
        PCSEL_XADR  = 3'd4
    } pcsel_e;

    typedef enum logic [1:0] {
        FS_RST   = 2'd0,
        FS_FETCH = 2'd1,
        FS_EXEC  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/irq_sync.sv
// Interrupt request synchronizer plus sticky pending flag with clear.
// Macro PC_FETCH_IRQ_SYNC_EN: when defined, an extra metastability flop sits
// in front of the pending flag; otherwise irq_in must be synchronous to clk.
module irq_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic irq_in,
    input  logic clr,
    output logic pending
);

    logic set_req;

`ifdef PC_FETCH_IRQ_SYNC_EN
    logic meta;

    // First synchronizer stage; the pending flag acts as the second stage.
    always_ff @(posedge clk) begin
        if (!reset_n) meta <= 1'b0;
        else          meta <= irq_in;
    end

    assign set_req = meta;
`else
    assign set_req = irq_in;
`endif

    // Pending latch: clear on the interrupt-taking commit wins over a new set.
    always_ff @(posedge clk) begin
        if (!reset_n)     pending <= 1'b0;
        else if (clr)     pending <= 1'b0;
        else if (set_req) pending <= 1'b1;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer (RST/FETCH/EXEC).
// Computes the next PC from PCSEL with supervisor-bit protection, fetches over
// a req/ack port and holds OPCODE, PC and IRQ stable through EXEC.
// Macro PC_FETCH_IRQ_SYNC_EN selects the two-flop IRQ_IN synchronizer.
module pc_fetch_unit
    import beta_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] ILLOP_VECTOR = DEF_ILLOP_VECTOR,
    parameter logic [31:0] XADR_VECTOR  = DEF_XADR_VECTOR
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [2:0]  PCSEL,
    input  logic [31:0] JT,
    input  logic        EXEC_DONE,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    input  logic        IRQ_IN,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    output logic [31:0] INSTR,
    output logic [5:0]  OPCODE,
    output logic        INSTR_VALID,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic        pc_31,
    output logic        IRQ
);

    fetch_state_e state;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic         req_q;
    logic         valid_q;
    logic         irq_q;
    logic         irq_pending;
    logic         commit;
    logic         irq_clr;
    logic [31:0]  pc_inc;
    logic [31:0]  br_target;
    logic [31:0]  pc_next;
    logic         unused_jt;

    assign unused_jt = ^JT[1:0];
    assign commit    = (state == FS_EXEC) && EXEC_DONE;
    assign irq_clr   = commit && (PCSEL == PCSEL_XADR);
    assign pc_inc    = pc_q + 32'd4;
    assign br_target = pc_inc + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    irq_sync u_irq_sync (
        .clk     (CLK),
        .reset_n (RESET_N),
        .irq_in  (IRQ_IN),
        .clr     (irq_clr),
        .pending (irq_pending)
    );

    // Next-PC selection; branch and JMP may never set the supervisor bit from user mode.
    always_comb begin
        pc_next = ILLOP_VECTOR;
        case (PCSEL)
            PCSEL_PC4:  pc_next = pc_inc;
            PCSEL_BR:   pc_next = {pc_q[31], br_target[30:0]};
            PCSEL_JMP:  pc_next = {pc_q[31] & JT[31], JT[30:2], 2'b00};
            PCSEL_XADR: pc_next = XADR_VECTOR;
            default:    pc_next = ILLOP_VECTOR;
        endcase
    end

    // Fetch/execute sequencer with registered outputs.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state   <= FS_RST;
            pc_q    <= RESET_VECTOR;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            case (state)
                FS_RST: begin
                    state <= FS_FETCH;
                    req_q <= 1'b1;
                end
                FS_FETCH: begin
                    if (IMEM_ACK) begin
                        instr_q <= IMEM_RDATA;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        irq_q   <= irq_pending & ~pc_q[31];
                        state   <= FS_EXEC;
                    end
                end
                FS_EXEC: begin
                    if (EXEC_DONE) begin
                        pc_q    <= pc_next;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                        irq_q   <= 1'b0;
                        state   <= FS_FETCH;
                    end
                end
                default: begin
                    state <= FS_RST;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign IMEM_REQ    = req_q;
    assign IMEM_ADDR   = pc_q;
    assign INSTR       = instr_q;
    assign OPCODE      = instr_q[31:26];
    assign INSTR_VALID = valid_q;
    assign PC          = pc_q;
    assign PC_PLUS4    = pc_inc;
    assign pc_31       = pc_q[31];
    assign IRQ         = irq_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  pcsel;
    logic [31:0] jt;
    logic        exec_done;
    logic        ack;
    logic [31:0] rdata;
    logic        irq_in;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_31;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_irq;
    logic        m_pend;
    logic        m_meta;
    bit          fetching;
    bit          executing;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .CLK         (clk),
        .RESET_N     (rst_n),
        .PCSEL       (pcsel),
        .JT          (jt),
        .EXEC_DONE   (exec_done),
        .IMEM_ACK    (ack),
        .IMEM_RDATA  (rdata),
        .IRQ_IN      (irq_in),
        .IMEM_REQ    (imem_req),
        .IMEM_ADDR   (imem_addr),
        .INSTR       (instr),
        .OPCODE      (opcode),
        .INSTR_VALID (instr_valid),
        .PC          (pc),
        .PC_PLUS4    (pc_plus4),
        .pc_31       (pc_31),
        .IRQ         (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [2:0] sel, input logic [31:0] cur,
                                             input logic [31:0] ins, input logic [31:0] tgt);
        logic [31:0] t;
        logic [15:0] imm;
        int          off;
        imm = ins[15:0];
        off = $signed(imm) * 4;
        case (sel)
            3'd0: return cur + 32'd4;
            3'd1: begin
                t = cur + 32'd4 + 32'(off);
                t[31] = cur[31];
                return t;
            end
            3'd2: return ((cur & tgt) & 32'h8000_0000) | (tgt & 32'h7FFF_FFFC);
            3'd4: return 32'h8000_0008;
            default: return 32'h8000_0004;
        endcase
    endfunction

    task automatic model_edge();
        bit clr;
        bit src;
        if (!rst_n) begin
            m_pc = 32'h8000_0000; m_instr = '0; m_irq = 1'b0; m_pend = 1'b0; m_meta = 1'b0;
            fetching = 0; executing = 0;
        end else begin
            clr = executing && exec_done && (pcsel == 3'd4);
`ifdef PC_FETCH_IRQ_SYNC_EN
            src = m_meta;
`else
            src = irq_in;
`endif
            if (fetching) begin
                if (ack) begin
                    m_instr = rdata;
                    m_irq = m_pend && !m_pc[31];
                    fetching = 0; executing = 1;
                end
            end else if (executing) begin
                if (exec_done) begin
                    m_pc = ref_next(pcsel, m_pc, m_instr, jt);
                    m_irq = 1'b0;
                    executing = 0; fetching = 1;
                end
            end else begin
                fetching = 1;
            end
            m_pend = clr ? 1'b0 : (m_pend | src);
            m_meta = irq_in;
        end
    endtask

    task automatic compare_all();
        check_eq("req", 32'(imem_req), 32'(fetching));
        if (fetching) check_eq("addr", imem_addr, m_pc);
        check_eq("pc", pc, m_pc);
        check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
        check_eq("pc_31", 32'(pc_31), 32'(m_pc[31]));
        check_eq("instr", instr, m_instr);
        check_eq("opcode", 32'(opcode), 32'(m_instr[31:26]));
        check_eq("valid", 32'(instr_valid), 32'(executing));
        check_eq("irq", 32'(irq), 32'(m_irq));
    endtask

    // One clock: inputs already driven, model follows the edge, outputs checked at negedge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // One full instruction from FETCH back to the next FETCH.
    task automatic do_instr(input logic [31:0] word, input int ack_wait,
                            input logic [2:0] sel, input logic [31:0] target, input int done_wait);
        ack = 1'b0;
        for (int i = 0; i < ack_wait; i++) tick();
        ack = 1'b1; rdata = word;
        tick();
        ack = 1'b0;
        for (int i = 0; i < done_wait; i++) tick();
        exec_done = 1'b1; pcsel = sel; jt = target;
        tick();
        exec_done = 1'b0; pcsel = 3'd0;
    endtask

    initial begin
        rst_n = 1'b0; pcsel = 3'd0; jt = '0; exec_done = 1'b0;
        ack = 1'b0; rdata = '0; irq_in = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check_eq("rst_pc", pc, 32'h8000_0000);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'd0);

        rst_n = 1'b1;
        tick();
        check_eq("seq_addr0", imem_addr, 32'h8000_0000);
        do_instr(32'h1234_5678, 0, 3'd0, '0, 0);
        check_eq("seq_addr1", imem_addr, 32'h8000_0004);
        do_instr(32'h0000_0001, 0, 3'd0, '0, 0);
        check_eq("seq_addr2", imem_addr, 32'h8000_0008);

        do_instr(32'h0, 0, 3'd2, 32'h0000_0100, 0);
        check_eq("jmp_to_user", pc, 32'h0000_0100);
        do_instr(32'h0000_FFFE, 0, 3'd1, '0, 1);
        check_eq("br_user", pc, 32'h0000_00FC);
        do_instr(32'h0, 0, 3'd2, 32'h0000_0040, 0);
        do_instr(32'h0, 0, 3'd2, 32'h8000_1234, 2);
        check_eq("jmp_user_prot", pc, 32'h0000_1234);
        do_instr(32'h0, 0, 3'd6, '0, 0);
        check_eq("illop", pc, 32'h8000_0004);
        do_instr(32'h0, 0, 3'd2, 32'h8000_0040, 0);
        do_instr(32'h0, 0, 3'd2, 32'h8000_1234, 0);
        check_eq("jmp_super", pc, 32'h8000_1234);
        do_instr(32'h0, 0, 3'd2, 32'h8000_0100, 0);
        do_instr(32'h0000_FFFE, 0, 3'd1, '0, 0);
        check_eq("br_super", pc, 32'h8000_00FC);

        // Fetch stalled by three cycles without ACK.
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_req", 32'(imem_req), 32'd1);
            check_eq("stall_addr", imem_addr, 32'h8000_00FC);
        end
        do_instr(32'h0, 0, 3'd2, 32'h0000_0200, 0);

        // Interrupt arriving mid-EXEC in user mode is deferred one instruction.
        ack = 1'b1; rdata = 32'hC000_0000;
        tick();
        ack = 1'b0;
        irq_in = 1'b1;
        tick();
        irq_in = 1'b0;
        tick();
        check_eq("irq_deferred", 32'(irq), 32'd0);
        exec_done = 1'b1; pcsel = 3'd0;
        tick();
        exec_done = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_eq("irq_taken", 32'(irq), 32'd1);
        exec_done = 1'b1; pcsel = 3'd4;
        tick();
        exec_done = 1'b0; pcsel = 3'd0;
        check_eq("xadr", pc, 32'h8000_0008);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_eq("irq_cleared", 32'(irq), 32'd0);

        // Supervisor mode masks IRQ.
        irq_in = 1'b1;
        tick();
        irq_in = 1'b0;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_eq("irq_masked", 32'(irq), 32'd0);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;

        // Reset during an outstanding fetch with a stray ACK.
        rst_n = 1'b0; ack = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        check_eq("mid_rst_req", 32'(imem_req), 32'd0);
        check_eq("mid_rst_pc", pc, 32'h8000_0000);
        check_eq("mid_rst_valid", 32'(instr_valid), 32'd0);
        tick();
        check_eq("mid_rst_instr", instr, 32'd0);
        rst_n = 1'b1; ack = 1'b0;
        tick();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            ack       = ($urandom_range(0, 2) != 0);
            exec_done = ($urandom_range(0, 2) != 0);
            pcsel     = 3'($urandom_range(0, 7));
            jt        = $urandom;
            rdata     = $urandom;
            irq_in    = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
